// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the write-back sequencer.
//   wb_state_t             : sequencer state encoding
//   SEL_ALU / SEL_MEM      : write-back mux select codes
//   TIMEOUT_CYCLES_DEFAULT : default memory wait limit (used only when
//                            WB_SEQUENCER_TIMEOUT_EN is defined)
// ----------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALU_WB  = 2'd1,
        MEM_REQ = 2'd2,
        MEM_WB  = 2'd3
    } wb_state_t;

    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    localparam int TIMEOUT_CYCLES_DEFAULT = 15;

endpackage

// File: rtl/wb_sequencer.sv
// ----------------------------------------------------------------------------
// wb_sequencer
// Sequences a single register-file write-back, either directly from an ALU
// result (one cycle) or from a memory load (request held until the memory
// returns valid data).
//
// Ports
//   CC_WB_CLOCK_50                 clock, rising edge
//   CC_WB_RESET_InLow              asynchronous active-low reset
//   CC_WB_Start_In                 request strobe, honoured only while idle
//   CC_WB_IsLoad_In                0 = ALU write-back, 1 = memory load
//   CC_WB_RegAddr_In               destination register
//   CC_WB_ALU_Data_Bus_In          ALU result
//   CC_WB_DataMemory_Data_Bus_In   load data
//   CC_WB_MemValid_In              load data valid
//   CC_WB_MemRead_Out              memory read request (level)
//   CC_WB_Selector_Out             write-back source, holds last used
//   CC_WB_RegWrite_Out             register-file write pulse
//   CC_WB_RegAddr_Out              register-file write address
//   CC_WB_Data_Bus_Out             registered write-back data
//   CC_WB_Busy_Out                 high whenever not idle
//   CC_WB_Done_Out                 completion pulse
//   CC_WB_Error_Out                load timeout pulse
//
// Configuration macro
//   WB_SEQUENCER_TIMEOUT_EN  when defined, a load that waits TIMEOUT_CYCLES
//                            cycles without MemValid is abandoned with an
//                            Error pulse; otherwise the load waits forever
//                            and Error is tied low.
// ----------------------------------------------------------------------------
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int REGADDR_WIDTH  = 5,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                     CC_WB_CLOCK_50,
    input  logic                     CC_WB_RESET_InLow,
    input  logic                     CC_WB_Start_In,
    input  logic                     CC_WB_IsLoad_In,
    input  logic [REGADDR_WIDTH-1:0] CC_WB_RegAddr_In,
    input  logic [DATAWIDTH_BUS-1:0] CC_WB_ALU_Data_Bus_In,
    input  logic [DATAWIDTH_BUS-1:0] CC_WB_DataMemory_Data_Bus_In,
    input  logic                     CC_WB_MemValid_In,
    output logic                     CC_WB_MemRead_Out,
    output logic                     CC_WB_Selector_Out,
    output logic                     CC_WB_RegWrite_Out,
    output logic [REGADDR_WIDTH-1:0] CC_WB_RegAddr_Out,
    output logic [DATAWIDTH_BUS-1:0] CC_WB_Data_Bus_Out,
    output logic                     CC_WB_Busy_Out,
    output logic                     CC_WB_Done_Out,
    output logic                     CC_WB_Error_Out
);

    // The wait counter is 8 bits wide, so the limit must fit 1..255.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout_cycles
        $error("wb_sequencer: TIMEOUT_CYCLES must be in 1..255");
    end

    wb_state_t                state_q;
    wb_state_t                state_d;
    logic [REGADDR_WIDTH-1:0] addr_q;
    logic [DATAWIDTH_BUS-1:0] data_q;
    logic                     sel_q;
    logic                     capture_addr;
    logic                     capture_alu;
    logic                     capture_mem;

`ifdef WB_SEQUENCER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] timeout_cnt_q;
    logic       error_q;
    logic       wait_expired;
    logic       timeout_hit;

    // The limit is reached when this cycle would be the last allowed miss.
    assign wait_expired = (timeout_cnt_q == TIMEOUT_LAST);
`endif

    // State register; reset drops straight to IDLE so MemRead falls at once.
    always_ff @(posedge CC_WB_CLOCK_50 or negedge CC_WB_RESET_InLow) begin
        if (!CC_WB_RESET_InLow) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the capture strobes for the datapath registers.
    // MemValid only matters in MEM_REQ, and Start only in IDLE, which gives
    // the ignore-while-busy behaviour without extra gating.
    always_comb begin
        state_d      = state_q;
        capture_addr = 1'b0;
        capture_alu  = 1'b0;
        capture_mem  = 1'b0;
`ifdef WB_SEQUENCER_TIMEOUT_EN
        timeout_hit  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (CC_WB_Start_In) begin
                    capture_addr = 1'b1;
                    if (CC_WB_IsLoad_In) begin
                        state_d = MEM_REQ;
                    end else begin
                        capture_alu = 1'b1;
                        state_d     = ALU_WB;
                    end
                end
            end
            ALU_WB: begin
                state_d = IDLE;
            end
            MEM_REQ: begin
                // Valid data wins over a timeout landing in the same cycle.
                if (CC_WB_MemValid_In) begin
                    capture_mem = 1'b1;
                    state_d     = MEM_WB;
                end
`ifdef WB_SEQUENCER_TIMEOUT_EN
                else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
`endif
            end
            MEM_WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers. The selector is only updated on the edge that
    // enters a write-back state, so it keeps the last used source while a
    // load is still waiting or after a timeout.
    always_ff @(posedge CC_WB_CLOCK_50 or negedge CC_WB_RESET_InLow) begin
        if (!CC_WB_RESET_InLow) begin
            addr_q <= '0;
            data_q <= '0;
            sel_q  <= SEL_ALU;
        end else begin
            if (capture_addr) begin
                addr_q <= CC_WB_RegAddr_In;
            end
            if (capture_alu) begin
                data_q <= CC_WB_ALU_Data_Bus_In;
                sel_q  <= SEL_ALU;
            end
            if (capture_mem) begin
                data_q <= CC_WB_DataMemory_Data_Bus_In;
                sel_q  <= SEL_MEM;
            end
        end
    end

`ifdef WB_SEQUENCER_TIMEOUT_EN
    // Wait counter: held at zero outside MEM_REQ so every load starts fresh,
    // counts each MEM_REQ cycle without MemValid. The error flag is a
    // registered copy of the timeout decision, so it pulses in the first
    // IDLE cycle and can never coincide with Done.
    always_ff @(posedge CC_WB_CLOCK_50 or negedge CC_WB_RESET_InLow) begin
        if (!CC_WB_RESET_InLow) begin
            timeout_cnt_q <= '0;
            error_q       <= 1'b0;
        end else begin
            error_q <= timeout_hit;
            if (state_q != MEM_REQ) begin
                timeout_cnt_q <= '0;
            end else if (!CC_WB_MemValid_In) begin
                timeout_cnt_q <= timeout_cnt_q + 8'd1;
            end
        end
    end

    assign CC_WB_Error_Out = error_q;
`else
    assign CC_WB_Error_Out = 1'b0;
`endif

    // Register %r0 is hardwired, so its write enable is suppressed while the
    // rest of the sequence (Done included) runs normally.
    assign CC_WB_Busy_Out     = (state_q != IDLE);
    assign CC_WB_MemRead_Out  = (state_q == MEM_REQ);
    assign CC_WB_Done_Out     = (state_q == ALU_WB) || (state_q == MEM_WB);
    assign CC_WB_RegWrite_Out = CC_WB_Done_Out && (addr_q != '0);
    assign CC_WB_Selector_Out = sel_q;
    assign CC_WB_RegAddr_Out  = addr_q;
    assign CC_WB_Data_Bus_Out = data_q;

endmodule

// File: doc/wb_sequencer.md
WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 32: width of ALU, memory and write-back data buses.
REQ-002 Parameter REGADDR_WIDTH, default 5: register-file destination address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 15: max memory wait cycles; range 1..255.
REQ-004 CC_WB_CLOCK_50  in  1  sole clock; all state updates on rising edge.
REQ-005 CC_WB_RESET_InLow  in  1  reset, asynchronous and active-low.
REQ-006 CC_WB_Start_In  in  1  request strobe, one cycle; sampled only when Busy_Out=0.
REQ-007 CC_WB_IsLoad_In  in  1  0 = ALU-result write-back, 1 = memory load; sampled with Start.
REQ-008 CC_WB_RegAddr_In  in  REGADDR_WIDTH  destination register; sampled with Start.
REQ-009 CC_WB_ALU_Data_Bus_In  in  DATAWIDTH_BUS  ALU result; sampled with Start.
REQ-010 CC_WB_DataMemory_Data_Bus_In  in  DATAWIDTH_BUS  load data; sampled when MemValid=1.
REQ-011 CC_WB_MemValid_In  in  1  memory read data valid.
REQ-012 CC_WB_MemRead_Out  out  1  memory read request, level, held until MemValid sampled.
REQ-013 CC_WB_Selector_Out  out  1  write-back mux select: 0 = ALU, 1 = memory.
REQ-014 CC_WB_RegWrite_Out  out  1  register-file write enable, one-cycle pulse.
REQ-015 CC_WB_RegAddr_Out  out  REGADDR_WIDTH  register-file write address.
REQ-016 CC_WB_Data_Bus_Out  out  DATAWIDTH_BUS  registered write-back data.
REQ-017 CC_WB_Busy_Out / CC_WB_Done_Out / CC_WB_Error_Out  out  1 each  busy level, completion pulse, timeout pulse.

Function
REQ-018 FSM states SHALL be IDLE, ALU_WB, MEM_REQ, MEM_WB; Busy_Out=1 in every state but IDLE.
REQ-019 IDLE + Start + IsLoad=0: capture addr/ALU data, go ALU_WB; next cycle RegWrite=1, Selector=0, Done=1, return IDLE (latency 1).
REQ-020 IDLE + Start + IsLoad=1: capture addr, go MEM_REQ; MemRead_Out=1 from next cycle.
REQ-021 MEM_REQ + MemValid=1: capture memory data, drop MemRead, go MEM_WB; next cycle RegWrite=1, Selector=1, Done=1, return IDLE.
REQ-022 MemValid=1 outside MEM_REQ SHALL be ignored.
REQ-023 Start while Busy_Out=1 SHALL be ignored, no queuing; Start in the cycle the FSM returns to IDLE is ignored (Busy still 1 that cycle).
REQ-024 RegAddr=0 (hardwired %r0): full sequence and Done pulse still occur, RegWrite_Out SHALL stay 0.
REQ-025 Selector_Out SHALL hold last-used source between operations; Data/RegAddr outputs hold last captured values.
REQ-026 Done_Out and Error_Out SHALL never assert in the same cycle.

Reset
REQ-027 Reset low SHALL immediately force IDLE, all outputs 0, data/address registers 0, timeout counter 0.
REQ-028 Reset mid-load SHALL drop MemRead_Out asynchronously; no write or Done follows release.
REQ-029 First Start accepted in the first clock edge after reset deassertion.

Configuration
REQ-030 Macro WB_SEQUENCER_TIMEOUT_EN defined: 8-bit counter clears on MEM_REQ entry, increments per MEM_REQ cycle without MemValid; at TIMEOUT_CYCLES consecutive waits, drop MemRead, pulse Error_Out one cycle, no RegWrite, no Done, return IDLE.
REQ-031 MemValid in the same cycle the counter reaches limit SHALL win (normal load completion).
REQ-032 Macro undefined: no counter; MEM_REQ waits indefinitely; Error_Out tied 0.

Structure
REQ-033 Shared package wb_pkg SHALL hold state encoding constants, selector codes SEL_ALU=0/SEL_MEM=1, default TIMEOUT_CYCLES.
REQ-034 Single module, no sub-module; timeout counter inline under the macro.

Verification
REQ-035 ALU: Start, IsLoad=0, addr=5, ALU=0x0000_00AA -> next cycle RegWrite=1, Sel=0, Addr=5, Data=0xAA, Done=1.
REQ-036 Load: Start, IsLoad=1, addr=9; MemValid after 3 cycles with 0xDEAD_BEEF -> MemRead high 3 cycles, then RegWrite=1, Sel=1, Data=0xDEADBEEF.
REQ-037 %r0: Start ALU, addr=0, data=0x1234 -> Done=1, RegWrite=0.
REQ-038 Busy: Start load, second Start (ALU, addr=7) during wait -> second ignored, exactly one write to addr of the load.
REQ-039 Timeout (macro on, TIMEOUT_CYCLES=4): load, no MemValid -> MemRead 4 cycles, Error pulse, no write; macro off -> MemRead stays high.
REQ-040 Reset pulse during MEM_REQ -> MemRead=0 immediately, Busy=0, no later RegWrite.
